// File: rtl/cr_kme_fifo_pkg.sv
// Shared definitions for the KME 132-bit entry FIFO and its consumers.
// An entry holds four payload words, the index of the last valid word and frame delimiters.
package cr_kme_fifo_pkg;

  localparam int KME_WORD_W        = 32;
  localparam int KME_WORDS         = 4;
  localparam int KME_ENT_PAYLOAD_W = KME_WORD_W * KME_WORDS;
  localparam int KME_ENT_LIDX_LSB  = KME_ENT_PAYLOAD_W;
  localparam int KME_ENT_LIDX_W    = 2;
  localparam int KME_ENT_SOP       = KME_ENT_LIDX_LSB + KME_ENT_LIDX_W;
  localparam int KME_ENT_EOP       = KME_ENT_SOP + 1;
  localparam int KME_ENT_W         = KME_ENT_EOP + 1;

  typedef struct packed {
    logic                         eop;
    logic                         sop;
    logic [KME_ENT_LIDX_W-1:0]    last_idx;
    logic [KME_ENT_PAYLOAD_W-1:0] payload;
  } kme_fifo_entry_t;

endpackage

// File: rtl/cr_kme_word_mux.sv
// Selects one WORD_W slice of a packed payload by index; word 0 sits in the low bits.
module cr_kme_word_mux #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic [WORDS*WORD_W-1:0] data_in,
  input  logic [IDX_W-1:0]        idx,
  output logic [WORD_W-1:0]       word
);

  always_comb begin
    word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == IDX_W'(k)) word = data_in[k*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/cr_kme_fifo_reader.sv
// Pops KME FIFO entries and serialises each payload into WORD_W words on a valid/ready stream,
// carrying sop/eop and flagging framing errors with a one-cycle pulse.
module cr_kme_fifo_reader
  import cr_kme_fifo_pkg::*;
#(
  parameter int DATA_SIZE = 132,
  parameter int WORD_W    = 32,
  parameter int WORDS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] fifo_out,
  input  logic                 fifo_out_valid,
  output logic                 fifo_out_ack,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 word_sop,
  output logic                 word_eop,
  output logic                 frame_err
);

  localparam int IDX_W = $clog2(WORDS);

  // Stream handshake: a word transfers on any cycle where word_valid and word_ready are both
  // high; once word_valid rises it stays high with word_out/sop/eop stable until that transfer.

  kme_fifo_entry_t  in_ent;
  kme_fifo_entry_t  hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hold_full_q, hold_full_d;
  logic             in_frame_q, in_frame_d;
  logic             frame_err_q, frame_err_d;
  logic             fire, last_fire, ack;

  always_comb begin
    in_ent          = '0;
    in_ent.payload  = fifo_out[KME_ENT_PAYLOAD_W-1:0];
    in_ent.last_idx = fifo_out[KME_ENT_LIDX_LSB +: KME_ENT_LIDX_W];
    in_ent.sop      = fifo_out[KME_ENT_SOP];
    in_ent.eop      = fifo_out[KME_ENT_EOP];
  end

  assign fire      = hold_full_q & word_ready;
  assign last_fire = fire & (idx_q == hold_q.last_idx);
  // Gated by rst so nothing is popped while the reader is held in reset.
  assign ack       = ~rst & fifo_out_valid & (~hold_full_q | last_fire);

  always_comb begin
    hold_d      = hold_q;
    idx_d       = idx_q;
    hold_full_d = hold_full_q;
    in_frame_d  = in_frame_q;
    frame_err_d = 1'b0;
    if (ack) begin
      hold_d      = in_ent;
      idx_d       = '0;
      hold_full_d = 1'b1;
      frame_err_d = (in_ent.sop & in_frame_q) | (~in_ent.sop & ~in_frame_q);
      in_frame_d  = ~in_ent.eop;
    end else if (last_fire) begin
      hold_full_d = 1'b0;
    end else if (fire) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      in_frame_q  <= in_frame_d;
      frame_err_q <= frame_err_d;
    end
  end

  cr_kme_word_mux #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .IDX_W  (IDX_W)
  ) u_word_mux (
    .data_in (hold_q.payload),
    .idx     (idx_q),
    .word    (word_out)
  );

  assign fifo_out_ack = ack;
  assign word_valid   = hold_full_q;
  assign word_sop     = hold_q.sop & (idx_q == '0);
  assign word_eop     = hold_q.eop & (idx_q == hold_q.last_idx);
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_cr_kme_fifo_reader.sv
// Directed bench for cr_kme_fifo_reader: a per-cycle vector table over a queued FIFO model,
// an in-order word scoreboard, and a hand-written reset-mid-frame sequence.
module tb_cr_kme_fifo_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [131:0] fifo_out;
  logic         fifo_out_valid;
  logic         fifo_out_ack;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         word_sop;
  logic         word_eop;
  logic         frame_err;

  cr_kme_fifo_reader #(
    .DATA_SIZE (132),
    .WORD_W    (32),
    .WORDS     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_out       (fifo_out),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack   (fifo_out_ack),
    .word_out       (word_out),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_sop       (word_sop),
    .word_eop       (word_eop),
    .frame_err      (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        valid;
    logic [31:0] word;
    logic        sop;
    logic        eop;
    logic        ack;
    logic        err;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  logic [131:0] fifo_q[$];
  logic [31:0]  exp_q[$];
  logic         ack_seen = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [131:0] mk(input logic sop, input logic eop, input logic [1:0] lidx,
                                      input logic [31:0] w3, input logic [31:0] w2,
                                      input logic [31:0] w1, input logic [31:0] w0);
    return {eop, sop, lidx, w3, w2, w1, w0};
  endfunction

  function automatic vec_t row(input logic ready, input logic valid, input logic [31:0] word,
                               input logic sop, input logic eop, input logic ack, input logic err);
    vec_t v;
    v.ready = ready; v.valid = valid; v.word = word;
    v.sop = sop; v.eop = eop; v.ack = ack; v.err = err;
    return v;
  endfunction

  // driver tasks
  task automatic push_fifo(input logic [131:0] ent);
    fifo_q.push_back(ent);
  endtask

  task automatic push_exp(input logic [131:0] ent);
    logic [1:0] lidx;
    lidx = ent[129:128];
    for (int k = 0; k <= int'(lidx); k++) exp_q.push_back(ent[k*32 +: 32]);
  endtask

  task automatic drive_fifo();
    fifo_out_valid = (fifo_q.size() > 0);
    fifo_out       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // One cycle: apply the pop seen last cycle, drive inputs at the falling edge, sample 1ns later.
  task automatic step(input logic ready, input logic rst_v);
    @(negedge clk);
    if (ack_seen) begin
      if (fifo_q.size() == 0) chk("fifo_underflow", 32'd1, 32'd0);
      else void'(fifo_q.pop_front());
    end
    rst        = rst_v;
    word_ready = ready;
    drive_fifo();
    #1;
    ack_seen = fifo_out_ack;
    if (word_valid && word_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", word_out, 32'hxxxxxxxx);
      else chk("sb_word_order", word_out, exp_q.pop_front());
    end
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("c%0d_valid", i), word_valid, v.valid);
    chk($sformatf("c%0d_ack", i), fifo_out_ack, v.ack);
    chk($sformatf("c%0d_err", i), frame_err, v.err);
    if (v.valid) begin
      chk($sformatf("c%0d_word", i), word_out, v.word);
      chk($sformatf("c%0d_sop", i), word_sop, v.sop);
      chk($sformatf("c%0d_eop", i), word_eop, v.eop);
    end
  endtask

  initial begin
    logic [131:0] e [1:10];

    e[1]  = mk(1, 1, 3, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111);
    e[2]  = mk(1, 0, 3, 32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555);
    e[3]  = mk(0, 1, 3, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999);
    e[4]  = mk(1, 1, 0, 32'hDEADDEAD, 32'hDEADDEAD, 32'hDEADDEAD, 32'h11111111);
    e[5]  = mk(1, 1, 1, 32'hDEADDEAD, 32'hDEADDEAD, 32'h34343434, 32'h12121212);
    e[6]  = mk(1, 1, 3, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111);
    e[7]  = mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'hE0E0E0E0);
    e[8]  = mk(1, 1, 0, 32'h0, 32'h0, 32'h0, 32'hF1F1F1F1);
    e[9]  = mk(1, 0, 3, 32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A);
    e[10] = mk(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5);

    //               ready valid word          sop eop ack err
    vecs[0]  = row(1, 0, 32'h0,        0, 0, 1, 0);
    vecs[1]  = row(1, 1, 32'h11111111, 1, 0, 0, 0);
    vecs[2]  = row(1, 1, 32'h22222222, 0, 0, 0, 0);
    vecs[3]  = row(1, 1, 32'h33333333, 0, 0, 0, 0);
    vecs[4]  = row(1, 1, 32'h44444444, 0, 1, 1, 0);
    vecs[5]  = row(1, 1, 32'h55555555, 1, 0, 0, 0);
    vecs[6]  = row(1, 1, 32'h66666666, 0, 0, 0, 0);
    vecs[7]  = row(1, 1, 32'h77777777, 0, 0, 0, 0);
    vecs[8]  = row(1, 1, 32'h88888888, 0, 0, 1, 0);
    vecs[9]  = row(1, 1, 32'h99999999, 0, 0, 0, 0);
    vecs[10] = row(1, 1, 32'hAAAAAAAA, 0, 0, 0, 0);
    vecs[11] = row(1, 1, 32'hBBBBBBBB, 0, 0, 0, 0);
    vecs[12] = row(1, 1, 32'hCCCCCCCC, 0, 1, 1, 0);
    vecs[13] = row(1, 1, 32'h11111111, 1, 1, 1, 0);
    vecs[14] = row(1, 1, 32'h12121212, 1, 0, 0, 0);
    vecs[15] = row(1, 1, 32'h34343434, 0, 1, 1, 0);
    vecs[16] = row(1, 1, 32'h11111111, 1, 0, 0, 0);
    vecs[17] = row(1, 1, 32'h22222222, 0, 0, 0, 0);
    vecs[18] = row(0, 1, 32'h33333333, 0, 0, 0, 0);
    vecs[19] = row(0, 1, 32'h33333333, 0, 0, 0, 0);
    vecs[20] = row(0, 1, 32'h33333333, 0, 0, 0, 0);
    vecs[21] = row(1, 1, 32'h33333333, 0, 0, 0, 0);
    vecs[22] = row(1, 1, 32'h44444444, 0, 1, 1, 0);
    vecs[23] = row(1, 1, 32'hE0E0E0E0, 0, 0, 1, 1);
    vecs[24] = row(1, 1, 32'hF1F1F1F1, 1, 1, 0, 1);
    vecs[25] = row(1, 0, 32'h0,        0, 0, 0, 0);

    rst = 1'b1;
    word_ready = 1'b1;
    fifo_out = '0;
    fifo_out_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push_fifo(e[i]);
      push_exp(e[i]);
    end

    // reset held for 3 cycles with the FIFO non-empty
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 1'b1);
      chk($sformatf("rst%0d_ack", r), fifo_out_ack, 32'd0);
      chk($sformatf("rst%0d_valid", r), word_valid, 32'd0);
      chk($sformatf("rst%0d_err", r), frame_err, 32'd0);
      chk($sformatf("rst%0d_word", r), word_out, 32'd0);
      chk($sformatf("rst%0d_sop", r), word_sop, 32'd0);
      chk($sformatf("rst%0d_eop", r), word_eop, 32'd0);
    end

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].ready, 1'b0);
      check_row(i, vecs[i]);
    end

    // reset in the middle of a frame: held entry is dropped and in_frame clears
    push_fifo(e[9]);
    push_exp(e[9]);
    step(1'b1, 1'b0);
    chk("mid_ack", fifo_out_ack, 32'd1);
    step(1'b1, 1'b0);
    chk("mid_w0", word_out, 32'h0A0A0A0A);
    chk("mid_w0_sop", word_sop, 32'd1);
    step(1'b1, 1'b0);
    chk("mid_w1", word_out, 32'h0B0B0B0B);
    push_fifo(e[10]);
    step(1'b1, 1'b1);
    chk("mid_rst_valid", word_valid, 32'd0);
    chk("mid_rst_ack", fifo_out_ack, 32'd0);
    exp_q.delete();
    step(1'b1, 1'b1);
    chk("mid_rst2_valid", word_valid, 32'd0);
    chk("mid_rst2_ack", fifo_out_ack, 32'd0);
    push_exp(e[10]);
    step(1'b1, 1'b0);
    chk("post_rst_ack", fifo_out_ack, 32'd1);
    chk("post_rst_valid", word_valid, 32'd0);
    step(1'b1, 1'b0);
    chk("post_rst_word", word_out, 32'hA5A5A5A5);
    chk("post_rst_valid1", word_valid, 32'd1);
    chk("post_rst_err", frame_err, 32'd1);
    chk("post_rst_eop", word_eop, 32'd1);
    chk("post_rst_sop", word_sop, 32'd0);
    step(1'b1, 1'b0);
    chk("tail_valid", word_valid, 32'd0);
    chk("tail_err", frame_err, 32'd0);

    // final report
    chk("sb_leftover_words", exp_q.size(), 32'd0);
    chk("fifo_leftover", fifo_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
